// File: rtl/adc_burst_scheduler.sv
// Purpose: sequence the dual-channel ADC SPI front-end in bursts, demux its A/B word stream into pairs.
// Latency: a pair is presented on out_ch_a/out_ch_b one cycle after the adc_valid that completes it.
// Backpressure: 1-deep output register; a pair completing while the register is full and not accepted is dropped and counted.
// Build option: define ADC_AVG_EN to emit one averaged pair per burst instead of every pair.
module adc_burst_scheduler #(
  parameter int PAIRS         = 8,
  parameter int PERIOD        = 50000,
  parameter int MIN_OFF       = 64,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic        periodic_en,
  output logic        adc_en,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_ch_a,
  output logic [11:0] out_ch_b,
  output logic [7:0]  out_seq,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int OW = $clog2(MIN_OFF + 1);
  localparam int DW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DISCARD, RUN, DRAIN} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           adc_en_nxt;
  logic [PW-1:0]  period_cnt;
  logic           period_hit;
  logic           pending;
  logic [OW-1:0]  off_cnt;
  logic [7:0]     word_idx;
  logic [DW-1:0]  drain_cnt;
  logic           start;
  logic           last_word;
  logic           drain_done;
  logic           pair_vld;
  logic [11:0]    pair_a;
  logic [11:0]    pair_b;

  assign period_hit = periodic_en && (period_cnt == PW'(PERIOD - 1));
  assign start      = (state == IDLE) && pending && (off_cnt == '0);
  assign last_word  = adc_valid && (word_idx == 8'(2 * PAIRS - 1));
  assign drain_done = (state == DRAIN) &&
                      (adc_valid || (drain_cnt == DW'(DRAIN_TIMEOUT - 1)));
  assign busy       = (state != IDLE);

`ifdef ADC_AVG_EN
  localparam int SH = $clog2(PAIRS);
  logic [18:0] sum_a;
  logic [18:0] sum_b;
  logic [18:0] tot_b;

  // The final B word is folded in combinationally so the average is ready on the closing strobe.
  assign tot_b    = sum_b + 19'(adc_data);
  assign pair_vld = (state == RUN) && last_word;
  assign pair_a   = 12'(sum_a >> SH);
  assign pair_b   = 12'(tot_b >> SH);

  // Accumulators cleared at burst start, summing A on even words and B on odd words.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_a <= '0;
      sum_b <= '0;
    end else if (start) begin
      sum_a <= '0;
      sum_b <= '0;
    end else if (state == RUN && adc_valid) begin
      if (word_idx[0]) sum_b <= tot_b;
      else             sum_a <= sum_a + 19'(adc_data);
    end
  end
`else
  logic [11:0] a_hold;

  assign pair_vld = (state == RUN) && adc_valid && word_idx[0];
  assign pair_a   = a_hold;
  assign pair_b   = adc_data;

  // Channel A word is held until its matching B word arrives.
  always_ff @(posedge clk) begin
    if (rst)                                          a_hold <= '0;
    else if (state == RUN && adc_valid && !word_idx[0]) a_hold <= adc_data;
  end
`endif

  // Next-state and enable decode; adc_en only moves on burst start and on the last pair.
  always_comb begin
    state_nxt  = state;
    adc_en_nxt = adc_en;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = DISCARD;
          adc_en_nxt = 1'b1;
        end
      end
      DISCARD: begin
        if (adc_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_word) begin
          state_nxt  = DRAIN;
          adc_en_nxt = 1'b0;
        end
      end
      DRAIN: begin
        if (drain_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt  = IDLE;
        adc_en_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered front-end enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      adc_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      adc_en <= adc_en_nxt;
    end
  end

  // Start requests: trigger and period timer merge into one pending flag; a new request wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cnt <= '0;
      pending    <= 1'b0;
    end else begin
      if (!periodic_en)    period_cnt <= '0;
      else if (period_hit) period_cnt <= '0;
      else                 period_cnt <= period_cnt + 1'b1;

      if (trig || period_hit) pending <= 1'b1;
      else if (start)         pending <= 1'b0;
    end
  end

  // Burst bookkeeping: enforced off time, word index, drain timeout and burst number.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt   <= OW'(MIN_OFF);
      word_idx  <= '0;
      drain_cnt <= '0;
      out_seq   <= '0;
    end else begin
      if (drain_done)                        off_cnt <= OW'(MIN_OFF);
      else if (state == IDLE && off_cnt != '0) off_cnt <= off_cnt - 1'b1;

      if (start)                          word_idx <= '0;
      else if (state == RUN && adc_valid) word_idx <= word_idx + 1'b1;

      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;

      if (drain_done) out_seq <= out_seq + 1'b1;
    end
  end

  // One-deep output register: a full, unaccepted register keeps its pair and the new one is counted as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_ch_a    <= '0;
      out_ch_b    <= '0;
      overrun_cnt <= '0;
    end else if (pair_vld) begin
      if (out_valid && !out_ready) begin
        if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
      end else begin
        out_valid <= 1'b1;
        out_ch_a  <= pair_a;
        out_ch_b  <= pair_b;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
